// File: rtl/mul4_pkg.sv
// Shared definitions for the 4x4 shift-add multiplier controller: state encoding,
// datapath select polarities and the control-word layout.
package mul4_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] P0   = 3'd2;
    localparam logic [2:0] P1   = 3'd3;
    localparam logic [2:0] P2   = 3'd4;
    localparam logic [2:0] P3   = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    localparam logic SEL_HI   = 1'b1;
    localparam logic SEL_LO   = 1'b0;
    localparam logic FB_SHIFT = 1'b1;
    localparam logic FB_HOLD  = 1'b0;

    localparam int unsigned PP_STEPS = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE = IDLE,
        ST_LOAD = LOAD,
        ST_P0   = P0,
        ST_P1   = P1,
        ST_P2   = P2,
        ST_P3   = P3,
        ST_DONE = DONE
    } state_e;

    typedef struct packed {
        logic ld_1;
        logic ld_2;
        logic s0;
        logic s1;
        logic s2;
        logic acc_clr;
        logic busy;
        logic done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = 8'h00;

    // Zero high halves mean only aL*bL contributes, so the first three steps add nothing.
    function automatic logic hi_halves_zero(input logic [1:0] a_hi, input logic [1:0] b_hi);
        return (a_hi == 2'b00) && (b_hi == 2'b00);
    endfunction

endpackage

// File: rtl/mul4_ctrl_decode.sv
// Moore output decode: maps a state encoding onto the datapath control word.
module mul4_ctrl_decode
    import mul4_pkg::*;
(
    input  logic [2:0] state,
    output ctrl_t      ctrl
);

    // Per-state control word; unused encodings decode as IDLE
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            IDLE: begin
                ctrl = CTRL_IDLE;
            end
            LOAD: begin
                ctrl.ld_1    = 1'b1;
                ctrl.acc_clr = 1'b1;
                ctrl.busy    = 1'b1;
            end
            P0: begin
                ctrl.ld_2 = 1'b1;
                ctrl.s0   = SEL_HI;
                ctrl.s1   = SEL_HI;
                ctrl.s2   = FB_HOLD;
                ctrl.busy = 1'b1;
            end
            P1: begin
                ctrl.ld_2 = 1'b1;
                ctrl.s0   = SEL_HI;
                ctrl.s1   = SEL_LO;
                ctrl.s2   = FB_SHIFT;
                ctrl.busy = 1'b1;
            end
            P2: begin
                ctrl.ld_2 = 1'b1;
                ctrl.s0   = SEL_LO;
                ctrl.s1   = SEL_HI;
                ctrl.s2   = FB_HOLD;
                ctrl.busy = 1'b1;
            end
            P3: begin
                ctrl.ld_2 = 1'b1;
                ctrl.s0   = SEL_LO;
                ctrl.s1   = SEL_LO;
                ctrl.s2   = FB_SHIFT;
                ctrl.busy = 1'b1;
            end
            DONE: begin
                ctrl.done = 1'b1;
            end
            default: begin
                ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mul4_controller.sv
// Sequencer for the 4x4 shift-add multiplier datapath. Define MUL4_CTRL_SKIP_EN to jump
// from LOAD straight to the last partial product when both operand high halves are zero.
module mul4_controller
    import mul4_pkg::*;
#(
    parameter bit DONE_PULSE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ack,
    input  logic [1:0] a_hi,
    input  logic [1:0] b_hi,
    output logic       ld_1,
    output logic       ld_2,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       acc_clr,
    output logic       busy,
    output logic       done
);

    state_e state_r;
    state_e state_next_s;
    ctrl_t  ctrl_next_s;
    ctrl_t  ctrl_r;
    logic   skip_s;

`ifdef MUL4_CTRL_SKIP_EN
    assign skip_s = hi_halves_zero(a_hi, b_hi);
`else
    logic unused_hi_s;
    assign unused_hi_s = ^{a_hi, b_hi};
    assign skip_s      = 1'b0;
`endif

    // Next-state selection; start is only honoured in IDLE and ack only in DONE
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (skip_s) begin
                    state_next_s = ST_P3;
                end else begin
                    state_next_s = ST_P0;
                end
            end
            ST_P0:   state_next_s = ST_P1;
            ST_P1:   state_next_s = ST_P2;
            ST_P2:   state_next_s = ST_P3;
            ST_P3:   state_next_s = ST_DONE;
            ST_DONE: begin
                if (DONE_PULSE || ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Decoding the state being entered lets the outputs come straight from flops
    mul4_ctrl_decode u_decode (
        .state (state_next_s),
        .ctrl  (ctrl_next_s)
    );

    // State and registered control word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ctrl_r  <= CTRL_IDLE;
        end else begin
            state_r <= state_next_s;
            ctrl_r  <= ctrl_next_s;
        end
    end

    assign ld_1    = ctrl_r.ld_1;
    assign ld_2    = ctrl_r.ld_2;
    assign s0      = ctrl_r.s0;
    assign s1      = ctrl_r.s1;
    assign s2      = ctrl_r.s2;
    assign acc_clr = ctrl_r.acc_clr;
    assign busy    = ctrl_r.busy;
    assign done    = ctrl_r.done;

endmodule

// File: tb/tb_mul4_controller.sv
// Scoreboarded bench for mul4_controller driving a small shift-add datapath model.
module tb_mul4_controller;

    logic       clk = 1'b0;
    logic       rst, start, ack, start_h, ack_h;
    logic [3:0] a_bus, b_bus;
    logic [1:0] hi_h;
    logic       ld_1, ld_2, s0, s1, s2, acc_clr, busy, done;
    logic       ld_1_h, ld_2_h, s0_h, s1_h, s2_h, acc_clr_h, busy_h, done_h;
    logic [7:0] vec, vec_h;
    logic [3:0] a_q = 4'd0, b_q = 4'd0;
    logic [7:0] acc = 8'd0;
    logic [3:0] pp;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       prev_done = 1'b0;

    typedef struct { int prod; int due; } exp_t;
    exp_t sb_q[$];

    logic [7:0] exp_seq [7] = '{8'h86, 8'h72, 8'h6A, 8'h52, 8'h4A, 8'h01, 8'h00};
    int         exp_acc [7] = '{0, 0, 2, 12, 13, 54, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul4_controller dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack),
        .a_hi(a_bus[3:2]), .b_hi(b_bus[3:2]),
        .ld_1(ld_1), .ld_2(ld_2), .s0(s0), .s1(s1), .s2(s2),
        .acc_clr(acc_clr), .busy(busy), .done(done)
    );

    mul4_controller #(.DONE_PULSE(1'b0)) dut_h (
        .clk(clk), .rst(rst), .start(start_h), .ack(ack_h),
        .a_hi(hi_h), .b_hi(hi_h),
        .ld_1(ld_1_h), .ld_2(ld_2_h), .s0(s0_h), .s1(s1_h), .s2(s2_h),
        .acc_clr(acc_clr_h), .busy(busy_h), .done(done_h)
    );

    assign vec   = {ld_1, ld_2, s0, s1, s2, acc_clr, busy, done};
    assign vec_h = {ld_1_h, ld_2_h, s0_h, s1_h, s2_h, acc_clr_h, busy_h, done_h};

    // Datapath the controller steers: operand registers and the shift-add accumulator
    assign pp = {2'b00, (s0 ? a_q[3:2] : a_q[1:0])} * {2'b00, (s1 ? b_q[3:2] : b_q[1:0])};
    always @(posedge clk) begin
        if (ld_1) begin
            a_q <= a_bus;
            b_q <= b_bus;
        end
        if (acc_clr) acc <= 8'd0;
        else if (ld_2) acc <= (s2 ? {acc[5:0], 2'b00} : acc) + {4'd0, pp};
    end

    // Reference latency: both operands below 4 may skip straight to the last step
    function automatic int exp_lat(input int a, input int b);
`ifdef MUL4_CTRL_SKIP_EN
        if (a < 4 && b < 4) return 3;
`endif
        return 6;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int a, input int b, input int due);
        exp_t e;
        e.prod = a * b;
        e.due  = due;
        sb_q.push_back(e);
    endtask

    task automatic issue(input int a, input int b, input bit track);
        @(negedge clk);
        a_bus = 4'(a);
        b_bus = 4'(b);
        start = 1'b1;
        if (track) push_exp(a, b, cyc + exp_lat(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, {31'd0, done}, 32'd1);
    endtask

    // Monitor: every done must match the oldest pending operation, on time, as a pulse
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_done: done=1 at cycle %0d, required no pending op", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("product", {24'd0, acc}, e.prod);
                check("done_cycle", cyc, e.due);
            end
            check("done_pulse", {31'd0, prev_done}, 32'd0);
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; start_h = 1'b0; ack_h = 1'b0;
        a_bus = 4'd0; b_bus = 4'd0; hi_h = 2'b01;
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, vec}, 32'd0);
        check("reset_outputs_hold", {24'd0, vec_h}, 32'd0);
        rst = 1'b0;

        // Full sequence with select triples and accumulator trace for 9*6
        issue(9, 6, 1'b1);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("seq_step%0d", k), {24'd0, vec}, {24'd0, exp_seq[k]});
            if (k >= 2 && k <= 5) check($sformatf("acc_step%0d", k), {24'd0, acc}, exp_acc[k]);
            @(negedge clk);
        end

        issue(15, 15, 1'b1);
        wait_done("ext_15x15");
        issue(0, 13, 1'b1);
        wait_done("ext_0x13");

        // start held for 10 cycles: one op, then a second one from the following IDLE
        @(negedge clk);
        a_bus = 4'd11; b_bus = 4'd13; start = 1'b1;
        push_exp(11, 13, cyc + exp_lat(11, 13));
        push_exp(11, 13, cyc + 2 * exp_lat(11, 13) + 1);
        repeat (10) @(negedge clk);
        start = 1'b0;
        wait_done("held_start");
        repeat (4) @(negedge clk);

        // Reset during P1 aborts with no done
        issue(9, 6, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("midrst_in_p1", {24'd0, vec}, 32'h6A);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {24'd0, vec}, 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(7, 5, 1'b1);
        wait_done("after_rst_7x5");

`ifdef MUL4_CTRL_SKIP_EN
        issue(3, 2, 1'b1);
        wait_done("skip_3x2");
        issue(4, 1, 1'b1);
        wait_done("noskip_4x1");
`endif

        for (int i = 0; i < 24; i++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            issue(ra, rb, 1'b1);
            wait_done($sformatf("rand%0d", i));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Held-done variant: ack outside DONE ignored, start ignored while waiting for ack
        @(negedge clk);
        start_h = 1'b1;
        @(negedge clk);
        start_h = 1'b0;
        ack_h = 1'b1;
        @(negedge clk);
        ack_h = 1'b0;
        begin
            int k = 0;
            while (done_h !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        check("hold_reach_done", {31'd0, done_h}, 32'd1);
        start_h = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold_done%0d", k), {31'd0, done_h}, 32'd1);
            check($sformatf("hold_no_load%0d", k), {31'd0, ld_1_h}, 32'd0);
            @(negedge clk);
        end
        start_h = 1'b0;
        ack_h = 1'b1;
        @(negedge clk);
        ack_h = 1'b0;
        check("hold_ack_release", {30'd0, done_h, busy_h}, 32'd0);
        @(negedge clk);
        check("hold_idle", {24'd0, vec_h}, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
